// File: rtl/exe_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arm_defs (package)
// Description : Shared encodings for the ARM-subset execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
package arm_defs;

    localparam logic [3:0] C_ALU_MOV = 4'b0001;
    localparam logic [3:0] C_ALU_MVN = 4'b1001;
    localparam logic [3:0] C_ALU_ADD = 4'b0010;
    localparam logic [3:0] C_ALU_ADC = 4'b0011;
    localparam logic [3:0] C_ALU_SUB = 4'b0100;
    localparam logic [3:0] C_ALU_SBC = 4'b0101;
    localparam logic [3:0] C_ALU_AND = 4'b0110;
    localparam logic [3:0] C_ALU_ORR = 4'b0111;
    localparam logic [3:0] C_ALU_EOR = 4'b1000;

    localparam logic [1:0] C_SH_LSL = 2'b00;
    localparam logic [1:0] C_SH_LSR = 2'b01;
    localparam logic [1:0] C_SH_ASR = 2'b10;
    localparam logic [1:0] C_SH_ROR = 2'b11;

    localparam logic [1:0] C_FWD_RF  = 2'b00;
    localparam logic [1:0] C_FWD_MEM = 2'b01;
    localparam logic [1:0] C_FWD_WB  = 2'b10;

    localparam int C_BIT_N = 3;
    localparam int C_BIT_Z = 2;
    localparam int C_BIT_C = 1;
    localparam int C_BIT_V = 0;

    // 2'b11 falls back to the register file, same as 2'b00.
    function automatic logic [31:0] f_forward(input logic [1:0]  sel,
                                              input logic [31:0] rf_val,
                                              input logic [31:0] mem_val,
                                              input logic [31:0] wb_val);
        case (sel)
            C_FWD_MEM: f_forward = mem_val;
            C_FWD_WB:  f_forward = wb_val;
            default:   f_forward = rf_val;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/exe_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : exe_stage_if
// Description : ID/EX inputs and EX/MEM outputs of the execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface exe_stage_if;
    logic [31:0] pc_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic        wb_enable_in;
    logic        branch_taken_in;
    logic        status_write_enable_in;
    logic [3:0]  alu_cmd_in;
    logic [31:0] val_rn_in;
    logic [31:0] val_rm_in;
    logic        immediate_in;
    logic [23:0] signed_immediate_in;
    logic [11:0] shift_operand_in;
    logic [3:0]  dest_reg_in;
    logic [1:0]  sel_src1;
    logic [1:0]  sel_src2;
    logic [31:0] mem_fwd_val;
    logic [31:0] wb_fwd_val;

    logic [31:0] branch_address;
    logic        branch_taken_out;
    logic [3:0]  status_out;
    logic [31:0] alu_result_out;
    logic [31:0] val_rm_out;
    logic [3:0]  dest_reg_out;
    logic        mem_read_out;
    logic        mem_write_out;
    logic        wb_enable_out;

    modport master (
        output pc_in, mem_read_in, mem_write_in, wb_enable_in, branch_taken_in,
               status_write_enable_in, alu_cmd_in, val_rn_in, val_rm_in,
               immediate_in, signed_immediate_in, shift_operand_in, dest_reg_in,
               sel_src1, sel_src2, mem_fwd_val, wb_fwd_val,
        input  branch_address, branch_taken_out, status_out, alu_result_out,
               val_rm_out, dest_reg_out, mem_read_out, mem_write_out, wb_enable_out
    );

    modport slave (
        input  pc_in, mem_read_in, mem_write_in, wb_enable_in, branch_taken_in,
               status_write_enable_in, alu_cmd_in, val_rn_in, val_rm_in,
               immediate_in, signed_immediate_in, shift_operand_in, dest_reg_in,
               sel_src1, sel_src2, mem_fwd_val, wb_fwd_val,
        output branch_address, branch_taken_out, status_out, alu_result_out,
               val_rm_out, dest_reg_out, mem_read_out, mem_write_out, wb_enable_out
    );
endinterface
`default_nettype wire

// File: rtl/exe_stage_val2_generator.sv
`default_nettype none
// ============================================================================
// Module      : val2_generator
// Description : Second-operand builder: mem offset, rotated immediate, shifted Rm.
// Revision    : 1.0 - initial release
// ============================================================================
module val2_generator
    import arm_defs::*;
(
    input  wire logic [31:0] val_rm,
    input  wire logic [11:0] shift_operand,
    input  wire logic        immediate,
    input  wire logic        mem_access,
    output logic [31:0]      val2
);

    logic [4:0]  w_rot;
    logic [4:0]  w_amt;
    logic [31:0] w_imm8;
    logic [31:0] w_imm_val;
    logic [31:0] w_shift_val;

    assign w_rot  = {shift_operand[11:8], 1'b0};
    assign w_amt  = shift_operand[11:7];
    assign w_imm8 = {24'b0, shift_operand[7:0]};

    // A left shift by 32 yields zero, so a zero rotate degenerates cleanly.
    assign w_imm_val = (w_imm8 >> w_rot) | (w_imm8 << (6'd32 - {1'b0, w_rot}));

    always_comb begin
        w_shift_val = val_rm;
        case (shift_operand[6:5])
            C_SH_LSL: w_shift_val = val_rm << w_amt;
            C_SH_LSR: w_shift_val = val_rm >> w_amt;
            C_SH_ASR: w_shift_val = $unsigned($signed(val_rm) >>> w_amt);
            C_SH_ROR: w_shift_val = (val_rm >> w_amt) | (val_rm << (6'd32 - {1'b0, w_amt}));
            default:  w_shift_val = val_rm;
        endcase
    end

    always_comb begin
        if (mem_access)
            val2 = {20'b0, shift_operand};
        else if (immediate)
            val2 = w_imm_val;
        else
            val2 = w_shift_val;
    end

endmodule
`default_nettype wire

// File: rtl/exe_stage.sv
`default_nettype none
// ============================================================================
// Module      : exe_stage
// Description : Execute stage with ALU, NZCV status and EX/MEM register.
// Revision    : 1.0 - initial release
// ============================================================================
module exe_stage
    import arm_defs::*;
(
    input  wire logic  clk,
    input  wire logic  rst,
    input  wire logic  freeze,
    exe_stage_if.slave bus
);

    logic [31:0] w_op1;
    logic [31:0] w_rm;
    logic [31:0] w_val2;
    logic [32:0] w_sum;
    logic [31:0] w_result;
    logic        w_cin;
    logic        w_c;
    logic        w_v;
    logic [3:0]  w_flags;

    logic [3:0]  r_status;
    logic [31:0] r_alu_result;
    logic [31:0] r_val_rm;
    logic [3:0]  r_dest_reg;
    logic        r_mem_read;
    logic        r_mem_write;
    logic        r_wb_enable;

    assign w_op1 = f_forward(bus.sel_src1, bus.val_rn_in, bus.mem_fwd_val, bus.wb_fwd_val);
    assign w_rm  = f_forward(bus.sel_src2, bus.val_rm_in, bus.mem_fwd_val, bus.wb_fwd_val);

    val2_generator u_val2 (
        .val_rm        (w_rm),
        .shift_operand (bus.shift_operand_in),
        .immediate     (bus.immediate_in),
        .mem_access    (bus.mem_read_in | bus.mem_write_in),
        .val2          (w_val2)
    );

    assign w_cin = r_status[C_BIT_C];

    // Subtraction is op1 + ~val2 + 1 so the carry-out is already NOT borrow.
    always_comb begin
        w_sum    = 33'd0;
        w_result = 32'd0;
        w_c      = r_status[C_BIT_C];
        w_v      = r_status[C_BIT_V];
        case (bus.alu_cmd_in)
            C_ALU_MOV: w_result = w_val2;
            C_ALU_MVN: w_result = ~w_val2;
            C_ALU_ADD, C_ALU_ADC: begin
                w_sum    = {1'b0, w_op1} + {1'b0, w_val2}
                         + {32'd0, (bus.alu_cmd_in == C_ALU_ADC) & w_cin};
                w_result = w_sum[31:0];
                w_c      = w_sum[32];
                w_v      = (w_op1[31] == w_val2[31]) && (w_sum[31] != w_op1[31]);
            end
            C_ALU_SUB, C_ALU_SBC: begin
                w_sum    = {1'b0, w_op1} + {1'b0, ~w_val2}
                         + {32'd0, (bus.alu_cmd_in == C_ALU_SBC) ? w_cin : 1'b1};
                w_result = w_sum[31:0];
                w_c      = w_sum[32];
                w_v      = (w_op1[31] != w_val2[31]) && (w_sum[31] != w_op1[31]);
            end
            C_ALU_AND: w_result = w_op1 & w_val2;
            C_ALU_ORR: w_result = w_op1 | w_val2;
            C_ALU_EOR: w_result = w_op1 ^ w_val2;
            default:   w_result = 32'd0;
        endcase
    end

    always_comb begin
        w_flags          = 4'd0;
        w_flags[C_BIT_N] = w_result[31];
        w_flags[C_BIT_Z] = (w_result == 32'd0);
        w_flags[C_BIT_C] = w_c;
        w_flags[C_BIT_V] = w_v;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_status     <= 4'd0;
            r_alu_result <= 32'd0;
            r_val_rm     <= 32'd0;
            r_dest_reg   <= 4'd0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_wb_enable  <= 1'b0;
        end else if (!freeze) begin
            r_alu_result <= w_result;
            r_val_rm     <= w_rm;
            r_dest_reg   <= bus.dest_reg_in;
            r_mem_read   <= bus.mem_read_in;
            r_mem_write  <= bus.mem_write_in;
            r_wb_enable  <= bus.wb_enable_in;
            if (bus.status_write_enable_in)
                r_status <= w_flags;
        end
    end

    assign bus.branch_address   = bus.pc_in + {{6{bus.signed_immediate_in[23]}},
                                               bus.signed_immediate_in, 2'b00};
    assign bus.branch_taken_out = bus.branch_taken_in;
    assign bus.status_out       = r_status;
    assign bus.alu_result_out   = r_alu_result;
    assign bus.val_rm_out       = r_val_rm;
    assign bus.dest_reg_out     = r_dest_reg;
    assign bus.mem_read_out     = r_mem_read;
    assign bus.mem_write_out    = r_mem_write;
    assign bus.wb_enable_out    = r_wb_enable;

endmodule
`default_nettype wire

// File: tb/tb_exe_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_exe_stage
// Description : Directed self-checking bench for exe_stage with a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exe_stage;

    logic clk    = 1'b0;
    logic rst    = 1'b0;
    logic freeze = 1'b0;
    logic chk_on = 1'b0;
    int   n_vec  = 0;
    int   n_miss = 0;

    exe_stage_if bus ();

    exe_stage dut (
        .clk    (clk),
        .rst    (rst),
        .freeze (freeze),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_ror(input logic [31:0] x, input int n);
        for (int i = 0; i < n; i++) x = {x[0], x[31:1]};
        return x;
    endfunction

    function automatic logic [31:0] m_asr(input logic [31:0] x, input int n);
        for (int i = 0; i < n; i++) x = {x[31], x[31:1]};
        return x;
    endfunction

    function automatic logic [31:0] m_fwd(input logic [1:0] sel, input logic [31:0] rf);
        if (sel == 2'b01) return bus.mem_fwd_val;
        if (sel == 2'b10) return bus.wb_fwd_val;
        return rf;
    endfunction

    function automatic logic [31:0] m_val2(input logic mem, input logic imm,
                                           input logic [11:0] so, input logic [31:0] rm);
        int amt;
        amt = int'(so[11:7]);
        if (mem) return {20'b0, so};
        if (imm) return m_ror({24'b0, so[7:0]}, 2 * int'(so[11:8]));
        case (so[6:5])
            2'b00:   return rm << amt;
            2'b01:   return rm >> amt;
            2'b10:   return m_asr(rm, amt);
            default: return m_ror(rm, amt);
        endcase
    endfunction

    function automatic logic ovf(input longint s);
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    // Returns {N,Z,C,V, result}.
    function automatic logic [35:0] m_alu(input logic [3:0] cmd, input logic [31:0] a,
                                          input logic [31:0] b, input logic [3:0] st);
        logic [31:0] r;
        logic        c, v, k;
        longint      u, s;
        r = 32'd0; c = st[1]; v = st[0]; u = 0; s = 0; k = 1'b0;
        case (cmd)
            4'b0001: r = b;
            4'b1001: r = ~b;
            4'b0010, 4'b0011: begin
                k = (cmd == 4'b0011) ? st[1] : 1'b0;
                u = longint'(a) + longint'(b) + longint'(k);
                s = longint'($signed(a)) + longint'($signed(b)) + longint'(k);
                r = u[31:0];
                c = (u > 64'sd4294967295);
                v = ovf(s);
            end
            4'b0100, 4'b0101: begin
                k = (cmd == 4'b0101) ? !st[1] : 1'b0;
                u = longint'(a) - longint'(b) - longint'(k);
                s = longint'($signed(a)) - longint'($signed(b)) - longint'(k);
                r = u[31:0];
                c = (u >= 0);
                v = ovf(s);
            end
            4'b0110: r = a & b;
            4'b0111: r = a | b;
            4'b1000: r = a ^ b;
            default: r = 32'd0;
        endcase
        return {r[31], r == 32'd0, c, v, r};
    endfunction

    logic [31:0] m_res, m_rm;
    logic [3:0]  m_st, m_dest;
    logic        m_mr, m_mw, m_wb;
    logic [35:0] m_now;
    logic [31:0] m_rm_now;

    assign m_rm_now = m_fwd(bus.sel_src2, bus.val_rm_in);
    assign m_now    = m_alu(bus.alu_cmd_in, m_fwd(bus.sel_src1, bus.val_rn_in),
                            m_val2(bus.mem_read_in | bus.mem_write_in, bus.immediate_in,
                                   bus.shift_operand_in, m_rm_now), m_st);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_res <= '0; m_rm <= '0; m_st <= '0; m_dest <= '0;
            m_mr <= 1'b0; m_mw <= 1'b0; m_wb <= 1'b0;
        end else if (!freeze) begin
            m_res  <= m_now[31:0];
            m_rm   <= m_rm_now;
            m_dest <= bus.dest_reg_in;
            m_mr   <= bus.mem_read_in;
            m_mw   <= bus.mem_write_in;
            m_wb   <= bus.wb_enable_in;
            if (bus.status_write_enable_in) m_st <= m_now[35:32];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("alu_result_out", bus.alu_result_out, m_res);
            chk("status_out", {28'd0, bus.status_out}, {28'd0, m_st});
            chk("val_rm_out", bus.val_rm_out, m_rm);
            chk("dest_reg_out", {28'd0, bus.dest_reg_out}, {28'd0, m_dest});
            chk("ctrl_out", {29'd0, bus.mem_read_out, bus.mem_write_out, bus.wb_enable_out},
                {29'd0, m_mr, m_mw, m_wb});
            chk("branch_address", bus.branch_address,
                bus.pc_in + 32'(int'($signed(bus.signed_immediate_in)) * 4));
            chk("branch_taken_out", {31'd0, bus.branch_taken_out}, {31'd0, bus.branch_taken_in});
        end
    end

    // ---------------- stimulus ----------------
    task automatic bubble();
        bus.pc_in = '0; bus.mem_read_in = 0; bus.mem_write_in = 0; bus.wb_enable_in = 0;
        bus.branch_taken_in = 0; bus.status_write_enable_in = 0; bus.alu_cmd_in = '0;
        bus.val_rn_in = '0; bus.val_rm_in = '0; bus.immediate_in = 0;
        bus.signed_immediate_in = '0; bus.shift_operand_in = '0; bus.dest_reg_in = '0;
        bus.sel_src1 = '0; bus.sel_src2 = '0; bus.mem_fwd_val = '0; bus.wb_fwd_val = '0;
    endtask

    task automatic issue(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                         input logic imm, input logic [11:0] so, input logic swe,
                         input logic wb);
        @(posedge clk); #1;
        bubble();
        bus.alu_cmd_in = cmd; bus.val_rn_in = rn; bus.val_rm_in = rm;
        bus.immediate_in = imm; bus.shift_operand_in = so;
        bus.status_write_enable_in = swe; bus.wb_enable_in = wb;
        bus.dest_reg_in = rn[3:0] ^ rm[3:0] ^ 4'h5;
    endtask

    task automatic expect_out(input string name, input logic [31:0] res, input logic [3:0] st);
        @(posedge clk); #1;
        bubble();
        @(negedge clk);
        chk({name, "_result"}, bus.alu_result_out, res);
        chk({name, "_status"}, {28'd0, bus.status_out}, {28'd0, st});
    endtask

    initial begin
        bubble();
        chk_on = 1'b1;
        @(negedge clk);
        chk("reset_result", bus.alu_result_out, 32'd0);
        chk("reset_status", {28'd0, bus.status_out}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        issue(4'b0010, 32'h7FFF_FFFF, 32'd0, 1'b1, 12'h001, 1'b1, 1'b1);
        expect_out("add_ovf", 32'h8000_0000, 4'b1001);

        issue(4'b0100, 32'd5, 32'd5, 1'b0, 12'h000, 1'b1, 1'b0);
        expect_out("cmp_eq", 32'd0, 4'b0110);
        chk("cmp_wb", {31'd0, bus.wb_enable_out}, 32'd0);

        issue(4'b0011, 32'hFFFF_FFFF, 32'd0, 1'b1, 12'h000, 1'b1, 1'b1);
        expect_out("adc_c", 32'd0, 4'b0110);

        issue(4'b0001, 32'd0, 32'd0, 1'b1, 12'h4FF, 1'b0, 1'b1);
        expect_out("mov_imm", 32'hFF00_0000, 4'b0110);

        issue(4'b0001, 32'd0, 32'h8000_0000, 1'b0, 12'h240, 1'b0, 1'b1);
        expect_out("asr4", 32'hF800_0000, 4'b0110);

        // Forwarded ADD, then a frozen ADD that must neither retire nor touch flags.
        issue(4'b0010, 32'd0, 32'd0, 1'b1, 12'h004, 1'b0, 1'b1);
        bus.sel_src1 = 2'b01; bus.mem_fwd_val = 32'h10;
        issue(4'b0010, 32'd1, 32'd0, 1'b1, 12'h001, 1'b1, 1'b1);
        freeze = 1'b1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("freeze_result", bus.alu_result_out, 32'h14);
        chk("freeze_status", {28'd0, bus.status_out}, {28'd0, 4'b0110});
        freeze = 1'b0;

        issue(4'b0001, 32'd0, 32'd0, 1'b0, 12'h000, 1'b0, 1'b0);
        bus.pc_in = 32'h100; bus.signed_immediate_in = 24'hFFFFFE; bus.branch_taken_in = 1'b1;
        @(negedge clk);
        chk("branch_addr", bus.branch_address, 32'h0000_00F8);
        chk("branch_taken", {31'd0, bus.branch_taken_out}, 32'd1);

        // Model-checked mix: shifts, logic ops, carries, invalid command, memory ops.
        issue(4'b0010, 32'd1, 32'h1234_5678, 1'b0, 12'h180, 1'b1, 1'b1);
        issue(4'b0111, 32'h0F00_0000, 32'h8765_4321, 1'b0, 12'h420, 1'b0, 1'b1);
        issue(4'b1000, 32'hFFFF_0000, 32'h8000_000F, 1'b0, 12'h260, 1'b1, 1'b1);
        issue(4'b1001, 32'd0, 32'h0000_00FF, 1'b0, 12'h000, 1'b1, 1'b1);
        issue(4'b0101, 32'd10, 32'd3, 1'b1, 12'h003, 1'b1, 1'b1);
        issue(4'b0101, 32'h8000_0000, 32'd0, 1'b1, 12'h001, 1'b1, 1'b1);
        issue(4'b0110, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b0, 12'h000, 1'b1, 1'b0);
        issue(4'b0011, 32'h7FFF_FFFF, 32'd0, 1'b1, 12'h000, 1'b1, 1'b1);
        issue(4'b1111, 32'h1234, 32'h5678, 1'b0, 12'h000, 1'b1, 1'b1);
        issue(4'b0010, 32'h1000, 32'h0, 1'b1, 12'h00C, 1'b0, 1'b0);
        bus.mem_write_in = 1'b1; bus.sel_src2 = 2'b10; bus.wb_fwd_val = 32'hDEAD_BEEF;
        issue(4'b0010, 32'h2000, 32'h0, 1'b1, 12'hF08, 1'b0, 1'b1);
        bus.mem_read_in = 1'b1; bus.sel_src1 = 2'b10; bus.wb_fwd_val = 32'h40;
        issue(4'b0100, 32'd3, 32'd5, 1'b0, 12'h000, 1'b1, 1'b0);
        bus.sel_src2 = 2'b11; bus.mem_fwd_val = 32'hFFFF_FFFF;
        issue(4'b0001, 32'd0, 32'hA5A5_0001, 1'b0, 12'hFE0, 1'b1, 1'b1);

        // Asynchronous reset arriving mid-freeze, between clock edges.
        freeze = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("async_rst_result", bus.alu_result_out, 32'd0);
        chk("async_rst_status", {28'd0, bus.status_out}, 32'd0);
        chk("async_rst_rm", bus.val_rm_out, 32'd0);
        chk("async_rst_dest", {28'd0, bus.dest_reg_out}, 32'd0);
        chk("async_rst_ctrl", {29'd0, bus.mem_read_out, bus.mem_write_out, bus.wb_enable_out},
            32'd0);
        @(negedge clk);
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exe_stage.md
# exe_stage

Execute stage of the 5-stage ARM-subset pipeline, sitting between the ID/EX pipeline register and the MEM stage. Each cycle it:
- forwards operands, builds the second operand (val2), runs the ALU and computes the branch target;
- holds the architectural NZCV status register;
- registers its results into the EX/MEM boundary, so it also acts as the EX/MEM pipeline register.

## Interface
Parameters: none.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- freeze  in  1  memory stall: hold all registered state this edge.
- pc_in  in  32  PC+4 of the instruction in EX.
- mem_read_in, mem_write_in, wb_enable_in  in  1 each  control from ID/EX.
- branch_taken_in, status_write_enable_in  in  1 each  control from ID/EX.
- alu_cmd_in  in  4  ALU command.
- val_rn_in, val_rm_in  in  32 each  register-file operands.
- immediate_in  in  1  I bit.
- signed_immediate_in  in  24  branch offset field.
- shift_operand_in  in  12  shifter operand field.
- dest_reg_in  in  4  destination register.
- sel_src1, sel_src2  in  2 each  forwarding select: 00 register file, 01 mem_fwd_val, 10 wb_fwd_val, 11 register file.
- mem_fwd_val, wb_fwd_val  in  32 each  forwarded results.
- branch_address  out  32  combinational branch target.
- branch_taken_out  out  1  combinational copy of branch_taken_in.
- status_out  out  4  registered {N,Z,C,V}.
- alu_result_out, val_rm_out  out  32 each  registered ALU result and store data (forwarded Rm).
- dest_reg_out  out  4  registered destination register.
- mem_read_out, mem_write_out, wb_enable_out  out  1 each  registered control.

## Operation
- Operands:
  - op1 = forward(sel_src1, val_rn_in).
  - rm = forward(sel_src2, val_rm_in).
- val2 selection, in priority order:
  - mem_read_in|mem_write_in: {20'b0, shift_operand_in}.
  - immediate_in: zero-extend shift_operand_in[7:0], then rotate right by 2*shift_operand_in[11:8].
  - Otherwise: rm shifted by shift_operand_in[11:7] (0–31). Shift type from [6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. Shift amount 0 passes rm unchanged.
- alu_cmd encoding:
  - 0001 MOV: val2.
  - 1001 MVN: ~val2.
  - 0010 ADD: op1+val2.
  - 0011 ADC: op1+val2+C.
  - 0100 SUB: op1−val2.
  - 0101 SBC: op1−val2−!C.
  - 0110 AND.
  - 0111 ORR.
  - 1000 EOR.
  - Any other code: result 0, flags N/Z from 0, C/V unchanged.
  - CMP uses 0100 and TST uses 0110 with wb disabled. LDR/STR use 0010.
- Flags:
  - N = result[31].
  - Z = (result == 0).
  - Arithmetic commands: C is the 33-bit carry-out; for SUB/SBC C = NOT borrow. V = signed overflow.
  - Logical and move commands: C and V are unchanged.
- branch_address = pc_in + (sign-extend(signed_immediate_in) << 2), modulo 2^32.

## Timing
- Reset (rst low, asynchronous): status_out, alu_result_out, val_rm_out, dest_reg_out, mem_read_out, mem_write_out and wb_enable_out are all 0.
- Latency: 1 cycle. The instruction presented at edge k appears on the registered outputs after edge k.
- status_out is written at the edge only when status_write_enable_in=1 and freeze=0.
  - The ALU in the same cycle uses the old C.
  - The next instruction sees the new flags.
- freeze=1: every register holds, including status. branch_address and branch_taken_out still track their inputs combinationally.
- freeze and status_write_enable_in both high: no status update.
- Reset asserted mid-freeze: reset wins immediately.
- A bubble from ID/EX arrives as all-zero control. It produces mem_read/mem_write/wb_enable = 0 and does not touch status.

## Structure
- Shared package `arm_defs` holds:
  - ALU command constants.
  - Shift type constants.
  - Forward-select constants.
  - NZCV bit indices.
- One sub-module, `val2_generator`, is combinational and holds the immediate rotate, the register shift and the mem-offset select.
- The ALU, status register and EX/MEM register live in exe_stage.

## Test plan
- ADD with overflow: op1=0x7FFFFFFF, val2=1, status_write_enable=1 → alu_result_out=0x80000000 and status_out=N1 Z0 C0 V1 after one edge.
- SUB equal: CMP 5,5 (0100), wb=0 → result 0, status Z1 C1 N0 V0, wb_enable_out=0.
- ADC with C set: previous status C=1, then ADC 0xFFFFFFFF+0 → result 0, flags Z1 C1.
- Operand shifts:
  - Immediate 0x4FF (rotate 4, i.e. ROR 8 of 0xFF) with MOV → 0xFF000000.
  - Register ASR #4 of 0x80000000 → 0xF8000000.
- Forwarding and branch:
  - sel_src1=01 with mem_fwd_val=0x10, ADD imm 0x04 → 0x14.
  - pc_in=0x100, signed_immediate=0xFFFFFE → branch_address=0xF8.
- freeze/reset: freeze=1 with a new ADD presented → outputs and status hold. Then rst low mid-stream → all outputs 0 without a clock edge.
